button_debouncer: RTL and testbench
===================================

// Module: button_debouncer
// PURPOSE
//   Debounces one mechanical button or switch whose input is already synchronised by a two-stage flop chain.
//   Produces a clean level plus single-cycle press and release pulses for the GPIO and interrupt logic.
//   Sits directly downstream of the synchroniser; one instance per button or switch.
// PARAMETERS
//   DEBOUNCE_CYCLES    325000   consecutive stable samples needed to accept a change (10 ms @ 32.5 MHz); must be >= 2
//   ACTIVE_LOW         0        0: pressed = in_sync high; 1: pressed = in_sync low
//   LONG_PRESS_CYCLES  32500000 cycles held in PRESSED before long_pulse fires (1 s); used only with the macro
// PORTS
//   clk            in   1  system clock
//   reset_n        in   1  reset, asynchronous, active-low
//   in_sync        in   1  synchronised raw button level
//   level          out  1  debounced state, 1 = pressed (polarity-corrected)
//   press_pulse    out  1  one-cycle pulse on accepted press
//   release_pulse  out  1  one-cycle pulse on accepted release
//   long_pulse     out  1  one-cycle pulse on long-press detection
// BEHAVIOUR
//   - Polarity: act = in_sync ^ ACTIVE_LOW. All outputs are registered.
//   - Reset: state = RELEASED; level, press_pulse, release_pulse, long_pulse = 0; all counters = 0.
//   - FSM states: RELEASED, DB_PRESS, PRESSED, DB_RELEASE.
//     - RELEASED: act=1 -> DB_PRESS, cnt <= 0.
//     - DB_PRESS:
//       - act=0 -> RELEASED (glitch rejected, no pulse).
//       - act=1 and cnt == DEBOUNCE_CYCLES-1 -> PRESSED; level <= 1, press_pulse <= 1.
//       - otherwise cnt++.
//     - PRESSED: act=0 -> DB_RELEASE, cnt <= 0.
//     - DB_RELEASE: mirror of DB_PRESS.
//       - act=1 -> PRESSED (no pulse).
//       - on completion -> RELEASED; level <= 0, release_pulse <= 1.
//   - Latency: first act sample at cycle 0 -> level and pulse asserted in cycle DEBOUNCE_CYCLES+1.
//   - Pulses: exactly one cycle wide; never two pulses in the same cycle.
//   - Counter: width $clog2(DEBOUNCE_CYCLES); never wraps, because the FSM leaves the DB state at the terminal count.
//   - Reset mid-debounce: in-flight transition aborted; no pulse emitted.
//   - Button held through reset release: treated as a fresh press; press_pulse after DEBOUNCE_CYCLES+1.
//   - Elaboration assertion: DEBOUNCE_CYCLES >= 2 and LONG_PRESS_CYCLES >= 1.
// CONFIGURATION
//   BUTTON_DEBOUNCER_LONG_PRESS_EN defined:
//     - hold_cnt ($clog2(LONG_PRESS_CYCLES+1) bits) counts cycles in PRESSED, cleared on entry to PRESSED.
//     - long_pulse fires once when hold_cnt reaches LONG_PRESS_CYCLES-1.
//     - hold_cnt then saturates; no repeat until a release is accepted.
//     - DB_RELEASE bouncing back to PRESSED does NOT clear hold_cnt.
//   Not defined: no hold counter logic; long_pulse tied to 0; port kept so the interface is stable.
// STRUCTURE
//   Package input_debounce_pkg:
//     - typedef enum logic [1:0] debounce_state_t {RELEASED, DB_PRESS, PRESSED, DB_RELEASE}
//     - localparam default cycle constants for the 32.5 MHz clock.
//   Sub-module debounce_counter:
//     - parameterised terminal count, ports clr / inc / done.
//     - instanced for cnt and, under the macro, for hold_cnt.
// TESTING (DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=8, ACTIVE_LOW=0 unless noted)
//   1. in_sync 0->1 at cycle 0, held -> level=1 and press_pulse=1 at cycle 5 only; release mirrors with release_pulse.
//   2. in_sync high 3 cycles then low -> level stays 0; no pulses; FSM returns to RELEASED.
//   3. Bounce train 1,0,1,1,0,1 then held high -> exactly one press_pulse, 5 cycles after the last 0->1 edge.
//   4. reset_n low for 1 cycle during DB_PRESS -> all outputs 0; re-press yields press_pulse after 5 cycles.
//   5. ACTIVE_LOW=1, in_sync 1->0 held -> level=1 and press_pulse at cycle 5.
//   6. Macro on, press held -> long_pulse one cycle 8 cycles after level rises, never repeats.
//      Macro off -> long_pulse constant 0.

Source files
------------

// File: rtl/input_debounce_pkg.sv
// Shared types and default timing constants for the button debouncer slice.
package input_debounce_pkg;

  typedef enum logic [1:0] {
    RELEASED   = 2'd0,
    DB_PRESS   = 2'd1,
    PRESSED    = 2'd2,
    DB_RELEASE = 2'd3
  } debounce_state_t;

  // Defaults derived from the 32.5 MHz system clock: 10 ms debounce, 1 s long press.
  localparam int unsigned CLK_FREQ_HZ               = 32_500_000;
  localparam int unsigned DEFAULT_DEBOUNCE_CYCLES   = CLK_FREQ_HZ / 100;
  localparam int unsigned DEFAULT_LONG_PRESS_CYCLES = CLK_FREQ_HZ;

endpackage

// File: rtl/debounce_counter.sv
// Saturating up-counter with synchronous clear; done flags the terminal count.
module debounce_counter #(
  parameter int unsigned TERMINAL = 1,
  parameter int unsigned WIDTH    = 1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic inc,
  output logic done
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  assign done = (cnt_q == WIDTH'(TERMINAL));

  // Clear wins over increment; the count holds once the terminal value is reached.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && !done) begin
      cnt_d = cnt_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/button_debouncer.sv
// Debounces one synchronised button input into a clean level plus press/release/long pulses.
// Long-press detection is built only when BUTTON_DEBOUNCER_LONG_PRESS_EN is defined.
module button_debouncer
  import input_debounce_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES   = DEFAULT_DEBOUNCE_CYCLES,
  parameter bit          ACTIVE_LOW        = 1'b0,
  parameter int unsigned LONG_PRESS_CYCLES = DEFAULT_LONG_PRESS_CYCLES
) (
  input  logic clk,
  input  logic reset_n,
  input  logic in_sync,
  output logic level,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);

  if (DEBOUNCE_CYCLES < 2 || LONG_PRESS_CYCLES < 1) begin : g_bad_params
    $error("button_debouncer: DEBOUNCE_CYCLES must be >= 2 and LONG_PRESS_CYCLES >= 1");
  end

  debounce_state_t state_q;
  debounce_state_t state_d;
  logic            level_q;
  logic            level_d;
  logic            press_q;
  logic            press_d;
  logic            release_q;
  logic            release_d;
  logic            act;
  logic            cnt_clr;
  logic            cnt_inc;
  logic            cnt_done;

  assign act = in_sync ^ ACTIVE_LOW;

  debounce_counter #(
    .TERMINAL (DEBOUNCE_CYCLES - 1),
    .WIDTH    (CNT_W)
  ) u_db_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (cnt_clr),
    .inc     (cnt_inc),
    .done    (cnt_done)
  );

  // A change is accepted only after the counter reaches its terminal value with act still stable.
  always_comb begin
    state_d   = state_q;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    case (state_q)
      RELEASED: begin
        if (act) begin
          state_d = DB_PRESS;
          cnt_clr = 1'b1;
        end
      end
      DB_PRESS: begin
        if (!act) begin
          state_d = RELEASED;
        end else if (cnt_done) begin
          state_d = PRESSED;
          level_d = 1'b1;
          press_d = 1'b1;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      PRESSED: begin
        if (!act) begin
          state_d = DB_RELEASE;
          cnt_clr = 1'b1;
        end
      end
      DB_RELEASE: begin
        if (act) begin
          state_d = PRESSED;
        end else if (cnt_done) begin
          state_d   = RELEASED;
          level_d   = 1'b0;
          release_d = 1'b1;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      default: begin
        state_d = RELEASED;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= RELEASED;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign level         = level_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;

`ifdef BUTTON_DEBOUNCER_LONG_PRESS_EN
  localparam int unsigned HOLD_W = $clog2(LONG_PRESS_CYCLES + 1);

  logic hold_inc;
  logic hold_done;
  logic long_q;
  logic long_d;
  logic long_fired_q;
  logic long_fired_d;

  // Cleared only on a fresh accepted press, so a rejected release bounce keeps the hold time.
  debounce_counter #(
    .TERMINAL (LONG_PRESS_CYCLES - 1),
    .WIDTH    (HOLD_W)
  ) u_hold_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (press_d),
    .inc     (hold_inc),
    .done    (hold_done)
  );

  // long_fired blocks repeats while the saturated hold count stays at terminal.
  always_comb begin
    hold_inc     = (state_q == PRESSED) && !hold_done;
    long_d       = (state_q == PRESSED) && hold_done && !long_fired_q;
    long_fired_d = press_d ? 1'b0 : (long_fired_q | long_d);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      long_q       <= 1'b0;
      long_fired_q <= 1'b0;
    end else begin
      long_q       <= long_d;
      long_fired_q <= long_fired_d;
    end
  end

  assign long_pulse = long_q;
`else
  assign long_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_button_debouncer.sv
// Bench for button_debouncer: directed literal checks plus randomized input against a run-length model.
module tb_button_debouncer;

  localparam int unsigned N = 4;
  localparam int unsigned L = 8;
`ifdef BUTTON_DEBOUNCER_LONG_PRESS_EN
  localparam bit LONG_EN = 1'b1;
`else
  localparam bit LONG_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic in_sync = 1'b0;
  logic lvl_h, prs_h, rel_h, lng_h;
  logic lvl_l, prs_l, rel_l, lng_l;

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 1'b0;

  always #5 clk = ~clk;

  button_debouncer #(.DEBOUNCE_CYCLES(N), .ACTIVE_LOW(1'b0), .LONG_PRESS_CYCLES(L)) dut_h (
    .clk(clk), .reset_n(reset_n), .in_sync(in_sync),
    .level(lvl_h), .press_pulse(prs_h), .release_pulse(rel_h), .long_pulse(lng_h)
  );

  button_debouncer #(.DEBOUNCE_CYCLES(N), .ACTIVE_LOW(1'b1), .LONG_PRESS_CYCLES(L)) dut_l (
    .clk(clk), .reset_n(reset_n), .in_sync(in_sync),
    .level(lvl_l), .press_pulse(prs_l), .release_pulse(rel_l), .long_pulse(lng_l)
  );

  // Model: level flips once act has disagreed with it for N+1 consecutive samples.
  // hold counts samples taken while pressed with no pending disagreement.
  typedef struct {
    int run;
    int hold;
    bit level;
    bit press;
    bit rel;
    bit lng;
  } mstate_t;

  mstate_t m[2];

  function automatic mstate_t step(mstate_t s, bit act);
    mstate_t n = s;
    n.press = 1'b0;
    n.rel   = 1'b0;
    n.lng   = 1'b0;
    if (LONG_EN && s.level && s.run == 0 && s.hold < int'(L)) begin
      if (s.hold == int'(L) - 1) n.lng = 1'b1;
      n.hold = s.hold + 1;
    end
    if (act != s.level) begin
      n.run = s.run + 1;
      if (n.run == int'(N) + 1) begin
        n.run   = 0;
        n.level = !s.level;
        if (n.level) begin
          n.press = 1'b1;
          n.hold  = 0;
        end else begin
          n.rel = 1'b1;
        end
      end
    end else begin
      n.run = 0;
    end
    return n;
  endfunction

  function automatic mstate_t mreset();
    mstate_t r;
    r.run = 0; r.hold = 0; r.level = 1'b0; r.press = 1'b0; r.rel = 1'b0; r.lng = 1'b0;
    return r;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m[0] <= mreset();
      m[1] <= mreset();
    end else begin
      m[0] <= step(m[0], in_sync);
      m[1] <= step(m[1], !in_sync);
    end
  end

  task automatic check(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%b expected=%b at t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      check("model level_h",   lvl_h, m[0].level);
      check("model press_h",   prs_h, m[0].press);
      check("model release_h", rel_h, m[0].rel);
      check("model long_h",    lng_h, m[0].lng);
      check("model level_l",   lvl_l, m[1].level);
      check("model press_l",   prs_l, m[1].press);
      check("model release_l", rel_l, m[1].rel);
      check("model long_l",    lng_l, m[1].lng);
    end
  end

  task automatic set_after_edge(input logic v);
    @(posedge clk);
    #2 in_sync = v;
  endtask

  initial begin
    bit train[6];
    train = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

    // Reset state, then release with in_sync low: active-low instance sees a held press.
    repeat (2) @(posedge clk);
    cmp_en = 1'b1;
    @(negedge clk);
    check("reset level_h", lvl_h, 1'b0);
    check("reset press_h", prs_h, 1'b0);
    check("reset release_h", rel_h, 1'b0);
    check("reset long_h", lng_h, 1'b0);
    check("reset level_l", lvl_l, 1'b0);
    check("reset press_l", prs_l, 1'b0);
    @(posedge clk);
    #2 reset_n = 1'b1;
    for (int k = 0; k <= 24; k++) begin
      @(negedge clk);
      check("held_thru_reset press_l", prs_l, k == 5);
      check("held_thru_reset level_l", lvl_l, k >= 5);
      check("held_thru_reset long_l", lng_l, LONG_EN && k == 13);
    end

    // Clean press on the active-high instance, release on the active-low one.
    set_after_edge(1'b1);
    for (int k = 0; k <= 20; k++) begin
      @(negedge clk);
      check("press level_h", lvl_h, k >= 5);
      check("press press_h", prs_h, k == 5);
      check("press long_h", lng_h, LONG_EN && k == 13);
      check("press release_l", rel_l, k == 5);
      check("press level_l", lvl_l, k < 5);
    end

    // Mirror: release on active-high, press on active-low.
    set_after_edge(1'b0);
    for (int k = 0; k <= 20; k++) begin
      @(negedge clk);
      check("release level_h", lvl_h, k < 5);
      check("release release_h", rel_h, k == 5);
      check("release long_h", lng_h, 1'b0);
      check("release press_l", prs_l, k == 5);
      check("release long_l", lng_l, LONG_EN && k == 13);
    end

    // Short glitch: three high samples are rejected.
    for (int k = 0; k <= 10; k++) begin
      set_after_edge(k < 3);
      @(negedge clk);
      check("glitch level_h", lvl_h, 1'b0);
      check("glitch press_h", prs_h, 1'b0);
      check("glitch level_l", lvl_l, 1'b1);
      check("glitch release_l", rel_l, 1'b0);
    end

    // Bounce train; last rising edge in cycle 5.
    for (int k = 0; k <= 20; k++) begin
      set_after_edge(k < 6 ? train[k] : 1'b1);
      @(negedge clk);
      check("bounce press_h", prs_h, k == 10);
      check("bounce level_h", lvl_h, k >= 10);
      check("bounce long_h", lng_h, LONG_EN && k == 18);
    end
    set_after_edge(1'b0);
    repeat (12) @(posedge clk);

    // Reset pulse during DB_PRESS aborts the transition; the held input is then a fresh press.
    for (int k = 0; k <= 12; k++) begin
      @(posedge clk);
      #2;
      if (k == 0) in_sync = 1'b1;
      if (k == 2) reset_n = 1'b0;
      if (k == 3) reset_n = 1'b1;
      @(negedge clk);
      check("midreset press_h", prs_h, k == 8);
      check("midreset level_h", lvl_h, k >= 8);
    end

    // Randomized bursts with occasional resets, checked by the model every cycle.
    for (int b = 0; b < 600; b++) begin
      logic v;
      int len;
      v   = 1'($urandom_range(0, 1));
      len = (($urandom_range(0, 3) == 0) ? int'($urandom_range(5, 14)) : int'($urandom_range(1, 5)));
      for (int i = 0; i < len; i++) begin
        set_after_edge(v);
        if ($urandom_range(0, 299) == 0) begin
          reset_n = 1'b0;
          repeat ($urandom_range(1, 3)) @(posedge clk);
          #2 reset_n = 1'b1;
        end
      end
    end
    repeat (3) @(negedge clk);
    cmp_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
